// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;
  typedef enum logic [1:0] {IDLE, ADD, SHIFT, DONE} mult_state_t;

  localparam int unsigned N_BITS   = 8;
  localparam logic [3:0]  S_ADD    = 4'b1001;
  localparam logic        M_ARITH  = 1'b0;
  localparam logic        CIN_ZERO = 1'b0;
  localparam logic [3:0]  CNT_LAST = 4'd7;
endpackage

// File: rtl/ula_8_bits.sv
// 8-bit 74181-style ALU, active-high data and active-high carry.
module ula_8_bits (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cin,
  output logic [7:0] f,
  output logic       cout
);
  logic [7:0] op1;
  logic [7:0] op2;
  logic [8:0] sum;
  logic [7:0] lf;

  // Arithmetic mode expressed as op1 + op2 + cin; "minus 1" terms add all ones.
  always_comb begin
    op1 = a;
    op2 = 8'h00;
    unique case (s)
      4'b0000: begin op1 = a;        op2 = 8'h00;    end
      4'b0001: begin op1 = a | b;    op2 = 8'h00;    end
      4'b0010: begin op1 = a | ~b;   op2 = 8'h00;    end
      4'b0011: begin op1 = 8'hFF;    op2 = 8'h00;    end
      4'b0100: begin op1 = a;        op2 = a & ~b;   end
      4'b0101: begin op1 = a | b;    op2 = a & ~b;   end
      4'b0110: begin op1 = a;        op2 = ~b;       end
      4'b0111: begin op1 = a & ~b;   op2 = 8'hFF;    end
      4'b1000: begin op1 = a;        op2 = a & b;    end
      4'b1001: begin op1 = a;        op2 = b;        end
      4'b1010: begin op1 = a | ~b;   op2 = a & b;    end
      4'b1011: begin op1 = a & b;    op2 = 8'hFF;    end
      4'b1100: begin op1 = a;        op2 = a;        end
      4'b1101: begin op1 = a | b;    op2 = a;        end
      4'b1110: begin op1 = a | ~b;   op2 = a;        end
      default: begin op1 = a;        op2 = 8'hFF;    end
    endcase
    sum = {1'b0, op1} + {1'b0, op2} + 9'(cin);
  end

  always_comb begin
    lf = 8'h00;
    unique case (s)
      4'b0000: lf = ~a;
      4'b0001: lf = ~(a | b);
      4'b0010: lf = ~a & b;
      4'b0011: lf = 8'h00;
      4'b0100: lf = ~(a & b);
      4'b0101: lf = ~b;
      4'b0110: lf = a ^ b;
      4'b0111: lf = a & ~b;
      4'b1000: lf = ~a | b;
      4'b1001: lf = ~(a ^ b);
      4'b1010: lf = b;
      4'b1011: lf = a & b;
      4'b1100: lf = 8'hFF;
      4'b1101: lf = a | ~b;
      4'b1110: lf = a | b;
      default: lf = a;
    endcase
  end

  assign f    = m ? lf : sum[7:0];
  assign cout = m ? 1'b0 : sum[8];
endmodule

// File: rtl/ctrl_mult_shift_add.sv
// Sequential 8x8 unsigned shift-add multiplier; the ALU does the conditional
// add, all shifting happens in the controller registers.
module ctrl_mult_shift_add
  import mult_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] p
);
  if (W != N_BITS) begin : g_bad_width
    $error("ctrl_mult_shift_add: W must equal 8");
  end

  mult_state_t state, state_n;
  logic [7:0]  m_r, m_n;
  logic [7:0]  acc, acc_n;
  logic [7:0]  q, q_n;
  logic        c_r, c_n;
  logic [3:0]  cnt, cnt_n;
  logic [15:0] p_n;
  logic        busy_n, done_n;
  logic [7:0]  f;
  logic        cout;

  ula_8_bits ula (
    .a    (acc),
    .b    (m_r),
    .s    (S_ADD),
    .m    (M_ARITH),
    .cin  (CIN_ZERO),
    .f    (f),
    .cout (cout)
  );

  // Next-state and next-register values.
  always_comb begin
    state_n = state;
    m_n     = m_r;
    acc_n   = acc;
    q_n     = q;
    c_n     = c_r;
    cnt_n   = cnt;
    p_n     = p;
    unique case (state)
      IDLE: begin
        if (start) begin
          m_n     = a[7:0];
          q_n     = b[7:0];
          acc_n   = 8'h00;
          c_n     = 1'b0;
          cnt_n   = 4'd0;
          state_n = ADD;
        end
      end
      ADD: begin
        if (q[0]) {c_n, acc_n} = {cout, f};
        else      c_n = 1'b0;
        state_n = SHIFT;
      end
      SHIFT: begin
        {c_n, acc_n, q_n} = {1'b0, c_r, acc, q[7:1]};
        cnt_n = cnt + 4'd1;
        if (cnt == CNT_LAST) begin
          p_n     = {c_r, acc, q[7:1]};
          state_n = DONE;
        end else begin
          state_n = ADD;
        end
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == ADD) || (state_n == SHIFT);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      m_r   <= 8'h00;
      acc   <= 8'h00;
      q     <= 8'h00;
      c_r   <= 1'b0;
      cnt   <= 4'd0;
      p     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      m_r   <= m_n;
      acc   <= acc_n;
      q     <= q_n;
      c_r   <= c_n;
      cnt   <= cnt_n;
      p     <= (2*W)'(p_n);
      busy  <= busy_n;
      done  <= done_n;
    end
  end
endmodule
